humidity_controller: RTL

HUMIDITY_CONTROLLER -- requirements
Module: humidity_controller

---
 rtl/humidity_controller_if.sv | 56 +++++
 rtl/humidity_controller.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/humidity_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : humidity_controller_if
//  Description : Sensor / setpoint / relay bundle for humidity_controller.
//                slave  modport : the controller (consumes humidity and
//                                 setpoints, drives relays and status).
//                master modport : whatever supplies humidity and setpoints
//                                 and observes the relay and status outputs.
//  Signals     : humidity[9:0]      RH in tenths of % (0-1000, may read up
//                                   to 1023)
//                setpoint_low[9:0]  start-misting threshold
//                setpoint_high[9:0] start-venting threshold
//                clear_fault        one-cycle pulse, clears mist_timeout
//                mister_on          mister relay drive
//                fan_on             vent fan relay drive
//                state[1:0]         IDLE=00 MIST=01 VENT=10 LOCKOUT=11
//                mist_timeout       sticky MIST timeout fault
//                cfg_error          setpoint_low >= setpoint_high
//  Revision    : 1.0 - initial release
// ============================================================================
interface humidity_controller_if;
    logic [9:0] humidity;
    logic [9:0] setpoint_low;
    logic [9:0] setpoint_high;
    logic       clear_fault;
    logic       mister_on;
    logic       fan_on;
    logic [1:0] state;
    logic       mist_timeout;
    logic       cfg_error;

    modport slave (
        input  humidity,
        input  setpoint_low,
        input  setpoint_high,
        input  clear_fault,
        output mister_on,
        output fan_on,
        output state,
        output mist_timeout,
        output cfg_error
    );

    modport master (
        output humidity,
        output setpoint_low,
        output setpoint_high,
        output clear_fault,
        input  mister_on,
        input  fan_on,
        input  state,
        input  mist_timeout,
        input  cfg_error
    );
endinterface
`default_nettype wire

// File: rtl/humidity_controller.sv
`default_nettype none
// ============================================================================
//  Module      : humidity_controller
//  Description : Mister / vent-fan controller. Humidity is sampled once per
//                SAMPLE_DIV cycles; CONFIRM consecutive out-of-band samples
//                start misting or venting, hysteresis plus a minimum on time
//                govern the exit, every run ends in a MIN_OFF lockout, and
//                misting is cut off after MAX_ON cycles with a sticky fault.
//  Ports       : clk    - system clock, rising edge
//                rst_n  - asynchronous active-low reset
//                bus    - humidity_controller_if.slave (sensor, setpoints,
//                         relay drives and status)
//  Revision    : 1.0 - initial release
// ============================================================================
module humidity_controller #(
    parameter int SAMPLE_DIV = 1000,
    parameter int CONFIRM    = 3,
    parameter int HYST       = 20,
    parameter int MIN_ON     = 50000,
    parameter int MAX_ON     = 5000000,
    parameter int MIN_OFF    = 100000
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    humidity_controller_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_MIST    = 2'b01,
        ST_VENT    = 2'b10,
        ST_LOCKOUT = 2'b11
    } state_t;

    localparam int c_TICK_W    = $clog2(SAMPLE_DIV);
    localparam int c_CNT_W     = $clog2(CONFIRM + 1);
    localparam int c_DWELL_TOP = (MAX_ON > MIN_OFF) ? MAX_ON : MIN_OFF;
    localparam int c_DWELL_W   = $clog2(c_DWELL_TOP + 1);

    localparam logic [c_TICK_W-1:0]  c_TICK_LAST = c_TICK_W'(SAMPLE_DIV - 1);
    localparam logic [c_CNT_W-1:0]   c_CONFIRM   = c_CNT_W'(CONFIRM);
    localparam logic [c_DWELL_W-1:0] c_DWELL_SAT = c_DWELL_W'(c_DWELL_TOP);
    localparam logic [c_DWELL_W-1:0] c_MIN_ON    = c_DWELL_W'(MIN_ON);
    localparam logic [c_DWELL_W-1:0] c_MAX_LAST  = c_DWELL_W'(MAX_ON - 1);
    localparam logic [c_DWELL_W-1:0] c_OFF_LAST  = c_DWELL_W'(MIN_OFF - 1);
    localparam logic [10:0]          c_HYST      = 11'(HYST);
    localparam logic [10:0]          c_RH_MAX    = 11'd1000;

    state_t                 r_state;
    logic                   r_mister_on;
    logic                   r_fan_on;
    logic                   r_mist_timeout;
    logic                   r_cfg_error;
    logic [c_TICK_W-1:0]    r_tick_cnt;
    logic [c_DWELL_W-1:0]   r_dwell;
    logic [c_CNT_W-1:0]     r_low_cnt;
    logic [c_CNT_W-1:0]     r_high_cnt;

    logic                   w_tick;
    logic [10:0]            w_sample;
    logic [10:0]            w_low_sum;
    logic [10:0]            w_low_exit;
    logic [10:0]            w_high_sp;
    logic [10:0]            w_high_exit;
    logic                   w_low_q;
    logic                   w_high_q;
    logic [c_CNT_W-1:0]     w_low_next;
    logic [c_CNT_W-1:0]     w_high_next;
    logic                   w_to_mist;
    logic                   w_to_vent;
    logic                   w_min_on_met;
    logic                   w_mist_dry_ok;
    logic                   w_vent_wet_ok;
    logic                   w_mist_max;
    logic                   w_off_done;

    assign w_tick = (r_tick_cnt == c_TICK_LAST);

    // Readings above 100.0 % are treated as exactly 100.0 %.
    assign w_sample = (bus.humidity > 10'd1000) ? c_RH_MAX : {1'b0, bus.humidity};

    // Exit thresholds: 11-bit sum so setpoint_low+HYST cannot wrap before the
    // 1000 clamp; setpoint_high-HYST floors at zero instead of underflowing.
    assign w_low_sum   = {1'b0, bus.setpoint_low} + c_HYST;
    assign w_low_exit  = (w_low_sum > c_RH_MAX) ? c_RH_MAX : w_low_sum;
    assign w_high_sp   = {1'b0, bus.setpoint_high};
    assign w_high_exit = (w_high_sp > c_HYST) ? (w_high_sp - c_HYST) : 11'd0;

    assign w_low_q     = (w_sample < {1'b0, bus.setpoint_low});
    assign w_high_q    = (w_sample > w_high_sp);
    assign w_low_next  = r_low_cnt + 1'b1;
    assign w_high_next = r_high_cnt + 1'b1;
    assign w_to_mist   = w_low_q  && (w_low_next  == c_CONFIRM);
    assign w_to_vent   = w_high_q && (w_high_next == c_CONFIRM);

    assign w_min_on_met  = (r_dwell >= c_MIN_ON);
    assign w_mist_dry_ok = w_tick && w_min_on_met && (w_sample >= w_low_exit);
    assign w_vent_wet_ok = w_tick && w_min_on_met && (w_sample <= w_high_exit);
    assign w_mist_max    = (r_dwell == c_MAX_LAST);
    assign w_off_done    = (r_dwell == c_OFF_LAST);

    // State, relay drives and counters share one register block so the
    // relays always change on the same edge as the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_mister_on    <= 1'b0;
            r_fan_on       <= 1'b0;
            r_mist_timeout <= 1'b0;
            r_cfg_error    <= 1'b0;
            r_tick_cnt     <= '0;
            r_dwell        <= '0;
            r_low_cnt      <= '0;
            r_high_cnt     <= '0;
        end else begin
            r_tick_cnt  <= w_tick ? '0 : r_tick_cnt + 1'b1;
            r_cfg_error <= (bus.setpoint_low >= bus.setpoint_high);

            if (r_dwell != c_DWELL_SAT) begin
                r_dwell <= r_dwell + 1'b1;
            end

            // A timeout set later in this block overrides this clear.
            if (bus.clear_fault) begin
                r_mist_timeout <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (r_cfg_error) begin
                        r_low_cnt  <= '0;
                        r_high_cnt <= '0;
                    end else if (w_tick) begin
                        if (w_to_mist) begin
                            r_state     <= ST_MIST;
                            r_mister_on <= 1'b1;
                            r_dwell     <= '0;
                            r_low_cnt   <= '0;
                            r_high_cnt  <= '0;
                        end else if (w_to_vent) begin
                            r_state    <= ST_VENT;
                            r_fan_on   <= 1'b1;
                            r_dwell    <= '0;
                            r_low_cnt  <= '0;
                            r_high_cnt <= '0;
                        end else begin
                            r_low_cnt  <= w_low_q  ? w_low_next  : '0;
                            r_high_cnt <= w_high_q ? w_high_next : '0;
                        end
                    end
                end

                ST_MIST: begin
                    if (w_mist_max || r_cfg_error || w_mist_dry_ok) begin
                        r_state     <= ST_LOCKOUT;
                        r_mister_on <= 1'b0;
                        r_dwell     <= '0;
                        if (w_mist_max) begin
                            r_mist_timeout <= 1'b1;
                        end
                    end
                end

                ST_VENT: begin
                    if (r_cfg_error || w_vent_wet_ok) begin
                        r_state  <= ST_LOCKOUT;
                        r_fan_on <= 1'b0;
                        r_dwell  <= '0;
                    end
                end

                default: begin
                    if (w_off_done) begin
                        r_state    <= ST_IDLE;
                        r_dwell    <= '0;
                        r_low_cnt  <= '0;
                        r_high_cnt <= '0;
                    end
                end
            endcase
        end
    end

    assign bus.mister_on    = r_mister_on;
    assign bus.fan_on       = r_fan_on;
    assign bus.state        = r_state;
    assign bus.mist_timeout = r_mist_timeout;
    assign bus.cfg_error    = r_cfg_error;

endmodule
`default_nettype wire
